calc_issue_ctrl: RTL and testbench
==================================

# calc_issue_ctrl

Issue controller and two-port arbiter for the shared calculate unit (integer ALU, bit-manipulation ALU, multiply/divide unit). It accepts operation requests from two requesters, grants them round-robin, and drives the unit's operand and mode inputs. It captures the single-cycle fast answer or the registered slow answer (mode 8'h4x), and returns the result with source, tag and error code through one valid/ready response port.

## Interface
- TAG_W, 4: width of the requester-supplied tag echoed with each result.
- IDLE_MODE, 8'hFF: mode code driven to the unit when no operation is being issued or held (TEST code).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle (handshake = valid & ready).
- req0_num1, req0_num2 / req1_num1, req1_num2  in  32  operands.
- req0_mode / req1_mode  in  8  calculate-unit mode code.
- req0_tag / req1_tag  in  TAG_W  opaque tag.
- cu_number1, cu_number2  out  32  operands to the unit.
- cu_mode  out  8  mode to the unit.
- cu_fast_answer  in  32  combinational result (modes 8'h0x–8'h3x).
- cu_slow_answer  in  32  result valid one cycle after issue (modes 8'h4x).
- cu_error  in  4  unit error code (0 none, 1 no instruction, 2 divide by zero).
- rsp_valid  out  1  result register full.
- rsp_ready  in  1  consumer takes result.
- rsp_src  out  1  granted requester (0 or 1).
- rsp_tag  out  TAG_W  echoed tag.
- rsp_data  out  32  result.
- rsp_error  out  4  captured cu_error.
- busy  out  1  high in WAIT or while rsp_valid.

## Operation
- States: IDLE, WAIT.
- can_accept = (state==IDLE) & (!rsp_valid | rsp_ready).
- Arbitration (IDLE only): if one request is valid, grant it. If both are valid, grant the one not granted last (pointer last_grant). last_grant updates only on a handshake.
- reqN_ready = can_accept & grant==N. The ungranted port's ready is 0.
- In IDLE, cu_number1/2 and cu_mode are driven combinationally from the granted request. With no valid request, they are driven with 0, 0 and IDLE_MODE.
- Slow op: cu_mode[7:4]==4'h4. All other modes, including undefined codes, are fast.
- Fast handshake: on the same edge, load rsp_data=cu_fast_answer, rsp_error=cu_error, rsp_src, rsp_tag, and set rsp_valid=1. State stays IDLE.
- Slow handshake: latch operands, mode, src and tag into hold registers, and go to WAIT. The rsp_valid drain in the same cycle still happens.
- WAIT: cu_* are driven from the hold registers, and both readies are 0. At the end of the cycle, load rsp_data=cu_slow_answer and rsp_error=cu_error, set rsp_valid=1, and return to IDLE.
- rsp_valid clears on rsp_valid & rsp_ready unless a new result loads on the same edge; a load takes priority.
- The rsp_* payload is held stable while rsp_valid & !rsp_ready.
- Invariant: rsp_valid is 0 during WAIT, so a slow capture never overwrites an unconsumed result.

## Timing
- Reset (async, immediate): state=IDLE, rsp_valid=0, rsp_data=0, rsp_error=0, rsp_src=0, rsp_tag=0, last_grant=1 (so req0 wins the first contention), busy=0, and cu_mode=IDLE_MODE when no request is valid.
- Fast latency: rsp_valid is high in the cycle after the handshake.
- Slow latency: rsp_valid is high 2 cycles after the handshake.
- Throughput:
  - Fast ops: 1 per cycle if rsp_ready stays high.
  - Slow ops: 1 per 2 cycles.
- Back-to-back fast ops: a result drained and a new one loaded on the same edge keep rsp_valid=1 continuously.
- Reset asserted in WAIT: the held op is dropped, no response is produced, and the next grant goes to req0.
- A requester that drops valid before ready is simply not granted. There is no obligation to hold requests.

## Test plan
- Fast op: req0 ADD (8'h01), num1=5, num2=7, tag=3 -> next cycle rsp_valid=1, rsp_data=12, rsp_src=0, rsp_tag=3, rsp_error=0.
- Slow op: req1 MUL (8'h40), 6×7 -> cu_mode=8'h40 held for 2 cycles, req0/req1_ready=0 in WAIT, rsp_data=42 two cycles after the handshake, rsp_src=1.
- Divide by zero: DIVU (8'h45), num1=9, num2=0 -> rsp_error=4'h2, rsp_data equals cu_slow_answer.
- Contention: both requesters continuously valid with fast ops after reset -> grants 0,1,0,1, and rsp_src alternates each cycle.
- Backpressure: rsp_ready=0 for 3 cycles after a fast result -> both readies 0, rsp payload stable; when rsp_ready rises, the next request is accepted the same cycle and its result follows 1 cycle later.
- Reset mid-WAIT: assert rst during a MUL in WAIT -> rsp_valid stays 0 and busy=0 immediately. After release, simultaneous requests grant req0 first.

Source files
------------

// File: rtl/calc_issue_ctrl.sv
// Issue controller and round-robin two-port arbiter for the shared calculate unit.
// Captures fast (same-cycle) or slow (mode 8'h4x, one cycle later) answers into one response register.
module calc_issue_ctrl #(
    parameter int          TAG_W     = 4,
    parameter logic [7:0]  IDLE_MODE = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_num1,
    input  logic [31:0]      req0_num2,
    input  logic [7:0]       req0_mode,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_num1,
    input  logic [31:0]      req1_num2,
    input  logic [7:0]       req1_mode,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      cu_number1,
    output logic [31:0]      cu_number2,
    output logic [7:0]       cu_mode,
    input  logic [31:0]      cu_fast_answer,
    input  logic [31:0]      cu_slow_answer,
    input  logic [3:0]       cu_error,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_src,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_data,
    output logic [3:0]       rsp_error,
    output logic             busy
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state, state_nxt;
    logic             last_grant;
    logic             grant;
    logic             any_req;
    logic             can_accept;
    logic             handshake;
    logic             slow_op;
    logic [31:0]      sel_num1, sel_num2;
    logic [7:0]       sel_mode;
    logic [TAG_W-1:0] sel_tag;
    logic [31:0]      hold_num1, hold_num2;
    logic [7:0]       hold_mode;
    logic             hold_src;
    logic [TAG_W-1:0] hold_tag;

    // Grant the lone valid requester; on contention, the one not served last.
    always_comb begin
        any_req = req0_valid | req1_valid;
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else
            grant = req1_valid;
        sel_num1 = grant ? req1_num1 : req0_num1;
        sel_num2 = grant ? req1_num2 : req0_num2;
        sel_mode = grant ? req1_mode : req0_mode;
        sel_tag  = grant ? req1_tag  : req0_tag;
    end

    assign can_accept = (state == IDLE) && (!rsp_valid || rsp_ready);
    assign handshake  = can_accept && any_req;
    assign slow_op    = (sel_mode[7:4] == 4'h4);
    assign busy       = (state == WAIT) || rsp_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (handshake && slow_op) state_nxt = WAIT;
            WAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cu_number1 = '0;
        cu_number2 = '0;
        cu_mode    = IDLE_MODE;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    cu_number1 = sel_num1;
                    cu_number2 = sel_num2;
                    cu_mode    = sel_mode;
                end
                req0_ready = can_accept && !grant;
                req1_ready = can_accept && grant;
            end
            WAIT: begin
                cu_number1 = hold_num1;
                cu_number2 = hold_num2;
                cu_mode    = hold_mode;
            end
            default: ;
        endcase
    end

    // A new load wins over the drain, keeping rsp_valid high on back-to-back ops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            hold_num1  <= '0;
            hold_num2  <= '0;
            hold_mode  <= IDLE_MODE;
            hold_src   <= 1'b0;
            hold_tag   <= '0;
            rsp_valid  <= 1'b0;
            rsp_src    <= 1'b0;
            rsp_tag    <= '0;
            rsp_data   <= '0;
            rsp_error  <= '0;
        end else begin
            if (handshake) begin
                last_grant <= grant;
                if (slow_op) begin
                    hold_num1 <= sel_num1;
                    hold_num2 <= sel_num2;
                    hold_mode <= sel_mode;
                    hold_src  <= grant;
                    hold_tag  <= sel_tag;
                end
            end
            if (state == WAIT) begin
                rsp_valid <= 1'b1;
                rsp_src   <= hold_src;
                rsp_tag   <= hold_tag;
                rsp_data  <= cu_slow_answer;
                rsp_error <= cu_error;
            end else if (handshake && !slow_op) begin
                rsp_valid <= 1'b1;
                rsp_src   <= grant;
                rsp_tag   <= sel_tag;
                rsp_data  <= cu_fast_answer;
                rsp_error <= cu_error;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_calc_issue_ctrl.sv
// Self-checking bench for calc_issue_ctrl with a small calculate-unit model and a response scoreboard.
module tb_calc_issue_ctrl;

    typedef struct packed {
        logic        v;
        logic [7:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
    } req_t;

    typedef struct packed {
        logic        src;
        logic [3:0]  tag;
        logic [31:0] data;
        logic [3:0]  err;
    } rsp_t;

    logic        clk, rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_num1, req0_num2, req1_num1, req1_num2;
    logic [7:0]  req0_mode, req1_mode;
    logic [3:0]  req0_tag, req1_tag;
    logic [31:0] cu_number1, cu_number2, cu_fast_answer, cu_slow_answer;
    logic [7:0]  cu_mode;
    logic [3:0]  cu_error;
    logic        rsp_valid, rsp_ready, rsp_src, busy;
    logic [3:0]  rsp_tag, rsp_error;
    logic [31:0] rsp_data;

    int   n_cmp = 0;
    int   n_bad = 0;
    rsp_t exp_q[$];
    rsp_t obs[256];
    int   obs_wr = 0;
    int   obs_rd = 0;

    calc_issue_ctrl #(.TAG_W(4), .IDLE_MODE(8'hFF)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_num1(req0_num1),
        .req0_num2(req0_num2), .req0_mode(req0_mode), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_num1(req1_num1),
        .req1_num2(req1_num2), .req1_mode(req1_mode), .req1_tag(req1_tag),
        .cu_number1(cu_number1), .cu_number2(cu_number2), .cu_mode(cu_mode),
        .cu_fast_answer(cu_fast_answer), .cu_slow_answer(cu_slow_answer), .cu_error(cu_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src), .rsp_tag(rsp_tag),
        .rsp_data(rsp_data), .rsp_error(rsp_error), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Calculate-unit model: ADD, SUB, MUL, DIVU; anything else is "no instruction".
    function automatic logic [31:0] unit_fn(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b);
        case (m)
            8'h01: unit_fn = a + b;
            8'h02: unit_fn = a - b;
            8'h40: unit_fn = a * b;
            8'h45: unit_fn = (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: unit_fn = 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] unit_err(input logic [7:0] m, input logic [31:0] b);
        case (m)
            8'h01, 8'h02, 8'h40: unit_err = 4'h0;
            8'h45: unit_err = (b == 0) ? 4'h2 : 4'h0;
            default: unit_err = 4'h1;
        endcase
    endfunction

    assign cu_fast_answer = unit_fn(cu_mode, cu_number1, cu_number2);
    assign cu_error       = unit_err(cu_mode, cu_number2);
    always @(posedge clk) cu_slow_answer <= unit_fn(cu_mode, cu_number1, cu_number2);

    // Observed responses: one entry per cycle in which valid and ready meet.
    always @(negedge clk) begin
        #2;
        if (!rst && rsp_valid && rsp_ready && obs_wr < 256) begin
            obs[obs_wr] = '{src: rsp_src, tag: rsp_tag, data: rsp_data, err: rsp_error};
            obs_wr = obs_wr + 1;
        end
    end

    function automatic req_t mk(input logic v, input logic [7:0] m, input logic [31:0] a,
                                input logic [31:0] b, input logic [3:0] t);
        mk = '{v: v, mode: m, a: a, b: b, tag: t};
    endfunction

    function automatic rsp_t exp_of(input logic s, input req_t q);
        exp_of = '{src: s, tag: q.tag, data: unit_fn(q.mode, q.a, q.b), err: unit_err(q.mode, q.b)};
    endfunction

    // Drives one cycle from a negedge, records expectations for accepted requests, returns at the next negedge.
    task automatic issue(input req_t q0, input req_t q1, input logic rr,
                         output logic r0, output logic r1, output logic [7:0] cm);
        req0_valid = q0.v; req0_mode = q0.mode; req0_num1 = q0.a; req0_num2 = q0.b; req0_tag = q0.tag;
        req1_valid = q1.v; req1_mode = q1.mode; req1_num1 = q1.a; req1_num2 = q1.b; req1_tag = q1.tag;
        rsp_ready  = rr;
        #1;
        r0 = req0_ready;
        r1 = req1_ready;
        cm = cu_mode;
        if (q0.v && r0) exp_q.push_back(exp_of(1'b0, q0));
        if (q1.v && r1) exp_q.push_back(exp_of(1'b1, q1));
        @(negedge clk);
    endtask

    task automatic test_reset;
        req_t z = mk(0, 0, 0, 0, 0);
        logic r0, r1;
        logic [7:0] cm;
        rst = 1'b1;
        issue(z, z, 1'b0, r0, r1, cm);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if ({rsp_src, rsp_tag, rsp_data, rsp_error} !== 41'h0)
            begin n_bad++; $display("FAIL reset_payload: got %h/%h/%h/%h want all 0", rsp_src, rsp_tag, rsp_data, rsp_error); end
        n_cmp++; if (cm !== 8'hFF || cu_number1 !== 32'h0 || cu_number2 !== 32'h0)
            begin n_bad++; $display("FAIL reset_cu: got mode %h n1 %h n2 %h want FF 0 0", cm, cu_number1, cu_number2); end
        rst = 1'b0;
    endtask

    task automatic test_fast;
        req_t z = mk(0, 0, 0, 0, 0);
        logic r0, r1;
        logic [7:0] cm;
        rsp_t e;
        issue(mk(1, 8'h01, 5, 7, 3), z, 1'b1, r0, r1, cm);
        n_cmp++; if ({r0, r1} !== 2'b10) begin n_bad++; $display("FAIL fast_ready: got %b want 10", {r0, r1}); end
        n_cmp++; if (cm !== 8'h01) begin n_bad++; $display("FAIL fast_cu_mode: got %h want 01", cm); end
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd12 || rsp_src !== 1'b0 || rsp_tag !== 4'd3 || rsp_error !== 4'd0)
            begin n_bad++; $display("FAIL fast_rsp: got v%b d%0d s%b t%0d e%0d want v1 d12 s0 t3 e0",
                                    rsp_valid, rsp_data, rsp_src, rsp_tag, rsp_error); end
        issue(z, z, 1'b1, r0, r1, cm);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_rd >= obs_wr) begin n_bad++; $display("FAIL fast_sb: got none want %h", e); end
            else begin
                if (obs[obs_rd] !== e) begin n_bad++; $display("FAIL fast_sb: got %h want %h", obs[obs_rd], e); end
                obs_rd++;
            end
        end
        n_cmp++; if (obs_rd != obs_wr) begin n_bad++; $display("FAIL fast_extra: got %0d responses want %0d", obs_wr, obs_rd); end
    endtask

    task automatic test_slow;
        req_t z = mk(0, 0, 0, 0, 0);
        logic r0, r1;
        logic [7:0] cm;
        rsp_t e;
        issue(z, mk(1, 8'h40, 6, 7, 5), 1'b1, r0, r1, cm);
        n_cmp++; if ({r0, r1} !== 2'b01 || cm !== 8'h40) begin n_bad++; $display("FAIL slow_issue: got rdy %b mode %h want 01 40", {r0, r1}, cm); end
        n_cmp++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL slow_wait_flags: got busy %b v %b want 1 0", busy, rsp_valid); end
        issue(mk(1, 8'h01, 1, 1, 0), z, 1'b1, r0, r1, cm);
        n_cmp++; if ({r0, r1} !== 2'b00 || cm !== 8'h40) begin n_bad++; $display("FAIL slow_wait: got rdy %b mode %h want 00 40", {r0, r1}, cm); end
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd42 || rsp_src !== 1'b1 || rsp_tag !== 4'd5)
            begin n_bad++; $display("FAIL slow_rsp: got v%b d%0d s%b t%0d want v1 d42 s1 t5", rsp_valid, rsp_data, rsp_src, rsp_tag); end
        issue(z, z, 1'b1, r0, r1, cm);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_rd >= obs_wr) begin n_bad++; $display("FAIL slow_sb: got none want %h", e); end
            else begin
                if (obs[obs_rd] !== e) begin n_bad++; $display("FAIL slow_sb: got %h want %h", obs[obs_rd], e); end
                obs_rd++;
            end
        end
    endtask

    task automatic test_divzero;
        req_t z = mk(0, 0, 0, 0, 0);
        logic r0, r1;
        logic [7:0] cm;
        rsp_t e;
        issue(mk(1, 8'h45, 9, 0, 2), z, 1'b1, r0, r1, cm);
        issue(z, z, 1'b1, r0, r1, cm);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_error !== 4'h2 || rsp_data !== 32'hFFFF_FFFF)
            begin n_bad++; $display("FAIL divzero_rsp: got v%b e%h d%h want v1 e2 dFFFFFFFF", rsp_valid, rsp_error, rsp_data); end
        issue(z, z, 1'b1, r0, r1, cm);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_rd >= obs_wr) begin n_bad++; $display("FAIL divzero_sb: got none want %h", e); end
            else begin
                if (obs[obs_rd] !== e) begin n_bad++; $display("FAIL divzero_sb: got %h want %h", obs[obs_rd], e); end
                obs_rd++;
            end
        end
    endtask

    task automatic test_contention;
        req_t z = mk(0, 0, 0, 0, 0);
        logic r0, r1;
        logic [7:0] cm;
        rsp_t e;
        rst = 1'b1;
        issue(z, z, 1'b0, r0, r1, cm);
        rst = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            issue(mk(1, 8'h01, 10, i, 1), mk(1, 8'h02, 50, i, 2), 1'b1, r0, r1, cm);
            n_cmp++; if (r0 !== (i % 2 == 0) || r1 !== (i % 2 == 1))
                begin n_bad++; $display("FAIL contention_grant[%0d]: got %b%b want %b%b", i, r0, r1, i % 2 == 0, i % 2 == 1); end
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_src !== i[0])
                begin n_bad++; $display("FAIL contention_src[%0d]: got v%b s%b want v1 s%b", i, rsp_valid, rsp_src, i[0]); end
        end
        issue(z, z, 1'b1, r0, r1, cm);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_rd >= obs_wr) begin n_bad++; $display("FAIL contention_sb: got none want %h", e); end
            else begin
                if (obs[obs_rd] !== e) begin n_bad++; $display("FAIL contention_sb: got %h want %h", obs[obs_rd], e); end
                obs_rd++;
            end
        end
    endtask

    task automatic test_backpressure;
        req_t z = mk(0, 0, 0, 0, 0);
        logic r0, r1;
        logic [7:0] cm;
        rsp_t e;
        issue(mk(1, 8'h01, 100, 1, 7), z, 1'b1, r0, r1, cm);
        for (int unsigned i = 0; i < 3; i++) begin
            issue(mk(1, 8'h01, 3, 3, 9), mk(1, 8'h01, 2, 2, 8), 1'b0, r0, r1, cm);
            n_cmp++; if ({r0, r1} !== 2'b00) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want 00", i, {r0, r1}); end
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd101 || rsp_tag !== 4'd7 || rsp_src !== 1'b0)
                begin n_bad++; $display("FAIL bp_hold[%0d]: got v%b d%0d t%0d s%b want v1 d101 t7 s0", i, rsp_valid, rsp_data, rsp_tag, rsp_src); end
        end
        issue(mk(1, 8'h01, 3, 3, 9), mk(1, 8'h01, 2, 2, 8), 1'b1, r0, r1, cm);
        n_cmp++; if ({r0, r1} !== 2'b01) begin n_bad++; $display("FAIL bp_release: got %b want 01", {r0, r1}); end
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd4 || rsp_src !== 1'b1 || rsp_tag !== 4'd8)
            begin n_bad++; $display("FAIL bp_next: got v%b d%0d s%b t%0d want v1 d4 s1 t8", rsp_valid, rsp_data, rsp_src, rsp_tag); end
        issue(z, z, 1'b1, r0, r1, cm);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_rd >= obs_wr) begin n_bad++; $display("FAIL bp_sb: got none want %h", e); end
            else begin
                if (obs[obs_rd] !== e) begin n_bad++; $display("FAIL bp_sb: got %h want %h", obs[obs_rd], e); end
                obs_rd++;
            end
        end
    endtask

    task automatic test_reset_wait;
        req_t z = mk(0, 0, 0, 0, 0);
        logic r0, r1;
        logic [7:0] cm;
        rsp_t e;
        issue(mk(1, 8'h40, 3, 4, 1), z, 1'b1, r0, r1, cm);
        n_cmp++; if (r0 !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL rw_enter: got rdy %b busy %b want 1 1", r0, busy); end
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rw_reset: got v%b busy %b want 0 0", rsp_valid, busy); end
        @(negedge clk);
        rst = 1'b0;
        issue(z, z, 1'b1, r0, r1, cm);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rw_no_rsp: got %b want 0", rsp_valid); end
        issue(mk(1, 8'h01, 20, 22, 4), mk(1, 8'h02, 9, 1, 6), 1'b1, r0, r1, cm);
        n_cmp++; if ({r0, r1} !== 2'b10) begin n_bad++; $display("FAIL rw_first_grant: got %b want 10", {r0, r1}); end
        issue(z, z, 1'b1, r0, r1, cm);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_rd >= obs_wr) begin n_bad++; $display("FAIL rw_sb: got none want %h", e); end
            else begin
                if (obs[obs_rd] !== e) begin n_bad++; $display("FAIL rw_sb: got %h want %h", obs[obs_rd], e); end
                obs_rd++;
            end
        end
        n_cmp++; if (obs_rd != obs_wr) begin n_bad++; $display("FAIL rw_extra: got %0d responses want %0d", obs_wr, obs_rd); end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_mode = '0; req0_num1 = '0; req0_num2 = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_mode = '0; req1_num1 = '0; req1_num2 = '0; req1_tag = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        test_reset;
        test_fast;
        test_slow;
        test_divzero;
        test_contention;
        test_backpressure;
        test_reset_wait;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
